// File: rtl/message_feeder_if.sv
// Ready/valid stream carrying messages from message_feeder to the DES core.
// The feeder is the master (drives data and valid); the core is the slave (drives ready).
interface message_feeder_if;
   logic [63:0] msg_out;
   logic        msg_valid;
   logic        msg_ready;

   modport master (output msg_out, output msg_valid, input msg_ready);
   modport slave  (input msg_out, input msg_valid, output msg_ready);
endinterface

// File: rtl/message_feeder.sv
// message_feeder: flow-control stage between message_counter and the DES core.
// It starts and seeds the counter, buffers the counter words in a FIFO and
// presents them on a ready/valid stream. When the FIFO runs low on free slots
// the counter is paused, then restarted from the last accepted word, so the
// core sees exactly num_messages consecutive messages.
// Optional build macro FEEDER_STATS_EN adds the pause_count_o statistics port.
module message_feeder #(
   parameter int DEPTH = 16,
   parameter int SLACK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [63:0]      message_seed_i,
   input  logic [31:0]      num_messages_i,
   output logic             counter_start_o,
   output logic [63:0]      counter_seed_o,
   input  logic [63:0]      counter_value_i,
   input  logic             counter_valid_i,
   message_feeder_if.master msg_if,
   output logic             done_o,
   output logic             overflow_o
`ifdef FEEDER_STATS_EN
   ,
   output logic [15:0]      pause_count_o
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
   localparam logic [PW:0] SLACK_C = (PW+1)'(SLACK);
   localparam logic [PW:0] HALF_C  = (PW+1)'(DEPTH / 2);

   typedef enum logic [2:0] {IDLE, RUN, PAUSE, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [63:0]   seedReg_q;
   logic [31:0]   remaining_q;
   logic          lastValid_q;
   logic          counterStart_q;
   logic          done_q;
   logic          overflow_q;
   logic [63:0]   mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [PW:0]   count_q;

   logic          active, abort, accept, acceptLast;
   logic          full, pop, doPush, drop;
   logic [PW:0]   freeSlots;

   // Decode the accept/abort conditions and the FIFO handshake for this cycle
   always_comb begin
      active     = (state_q == RUN) || (state_q == PAUSE) || (state_q == DRAIN);
      abort      = active && !start_i;
      accept     = active && start_i && counter_valid_i && (remaining_q != '0);
      acceptLast = accept && (remaining_q == 32'd1);
      full       = (count_q == DEPTH_C);
      pop        = (count_q != '0) && msg_if.msg_ready;
      doPush     = accept && (!full || pop);
      drop       = accept && full && !pop;
      freeSlots  = DEPTH_C - count_q;
   end

   // Next-state decision; running out of messages in PAUSE also heads for DRAIN
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = (num_messages_i == '0) ? DONE : RUN;
         end
         RUN: begin
            if (!start_i)                                 state_d = IDLE;
            else if (acceptLast || remaining_q == '0)     state_d = DRAIN;
            else if (freeSlots <= SLACK_C)                state_d = PAUSE;
         end
         PAUSE: begin
            if (!start_i)                                 state_d = IDLE;
            else if (acceptLast || remaining_q == '0)     state_d = DRAIN;
            else if (!lastValid_q && !counter_valid_i && freeSlots >= HALF_C)
                                                          state_d = RUN;
         end
         DRAIN: begin
            if (!start_i)                                 state_d = IDLE;
            else if (count_q == '0)                       state_d = DONE;
         end
         DONE: begin
            if (!start_i)                                 state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, registered outputs, remaining count and re-seed point
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         counterStart_q <= 1'b0;
         done_q         <= 1'b0;
         lastValid_q    <= 1'b0;
         seedReg_q      <= '0;
         remaining_q    <= '0;
      end else begin
         state_q        <= state_d;
         counterStart_q <= (state_d == RUN);
         done_q         <= (state_d == DONE);
         lastValid_q    <= counter_valid_i;
         if (state_q == IDLE && start_i) begin
            seedReg_q   <= message_seed_i;
            remaining_q <= num_messages_i;
         end else if (accept) begin
            seedReg_q   <= counter_value_i;
            remaining_q <= remaining_q - 32'd1;
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow; an abort flushes the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (abort) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
         if (pop)    rdPtr_q <= rdPtr_q + PW'(1);
         if (doPush && !pop)      count_q <= count_q + (PW+1)'(1);
         else if (pop && !doPush) count_q <= count_q - (PW+1)'(1);
         if (drop) overflow_q <= 1'b1;
      end
   end

   // FIFO storage; written only when a word is actually enqueued
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= counter_value_i;
   end

`ifdef FEEDER_STATS_EN
   logic [15:0] pauseCount_q;

   // Count RUN->PAUSE transitions, saturating, cleared when a new run starts
   always_ff @(posedge clk) begin
      if (rst) begin
         pauseCount_q <= '0;
      end else if (state_q == IDLE && state_d == RUN) begin
         pauseCount_q <= '0;
      end else if (state_q == RUN && state_d == PAUSE && pauseCount_q != 16'hFFFF) begin
         pauseCount_q <= pauseCount_q + 16'd1;
      end
   end

   assign pause_count_o = pauseCount_q;
`else
   // Default build carries no pause statistics.
`endif

   assign counter_start_o  = counterStart_q;
   assign counter_seed_o   = seedReg_q;
   assign done_o           = done_q;
   assign overflow_o       = overflow_q;
   assign msg_if.msg_valid = (count_q != '0);
   assign msg_if.msg_out   = (count_q != '0) ? mem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_message_feeder.sv
// Testbench for message_feeder. A behavioural message_counter drives the
// counter inputs; a scoreboard expects the delivered stream to be exactly
// seed+1, seed+2, ... for the current run, and directed checks pin the
// scoreboard with hand-computed literals.
module tb_message_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] messageSeed;
   logic [31:0] numMessages;
   logic        counterStart;
   logic [63:0] counterSeed;
   logic [63:0] counterValue;
   logic        counterValid;
   logic        done;
   logic        overflow;
`ifdef FEEDER_STATS_EN
   logic [15:0] pauseCount;
`endif

   message_feeder_if msgIf ();

   message_feeder #(.DEPTH(16), .SLACK(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start),
      .message_seed_i  (messageSeed),
      .num_messages_i  (numMessages),
      .counter_start_o (counterStart),
      .counter_seed_o  (counterSeed),
      .counter_value_i (counterValue),
      .counter_valid_i (counterValid),
      .msg_if          (msgIf.master),
      .done_o          (done),
      .overflow_o      (overflow)
`ifdef FEEDER_STATS_EN
      ,
      .pause_count_o   (pauseCount)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural message_counter: valid two cycles after start rises,
   // seed+1 first, +1 per cycle, one extra valid cycle after start falls.
   logic        cmArmed, cmValid;
   logic [63:0] cmCnt, cmValue;
   logic        forceEn, forceValid;
   logic [63:0] forceValue;

   always @(posedge clk) begin
      if (rst) begin
         cmArmed <= 1'b0;
         cmValid <= 1'b0;
         cmCnt   <= '0;
         cmValue <= '0;
      end else if (counterStart) begin
         if (!cmArmed) begin
            cmArmed <= 1'b1;
            cmCnt   <= counterSeed;
            cmValid <= 1'b0;
         end else begin
            cmValid <= 1'b1;
            cmValue <= cmCnt + 64'd1;
            cmCnt   <= cmCnt + 64'd1;
         end
      end else begin
         cmArmed <= 1'b0;
         cmValid <= 1'b0;
      end
   end

   assign counterValid = forceEn ? forceValid : cmValid;
   assign counterValue = forceEn ? forceValue : cmValue;

   int unsigned checks = 0;
   int unsigned passes = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
   endtask

   // Scoreboard state for the current run
   logic        sbEnable = 1'b0;
   logic        allowOverflow = 1'b0;
   logic [63:0] expBase = '0;
   int unsigned expN = 0;
   int unsigned rxCount = 0;
   logic [63:0] firstWord = '0, lastWord = '0;
   int unsigned cycleCount = 0;
   int unsigned firstCycle = 0, lastCycle = 0;
   logic        prevHold = 1'b0;
   logic [63:0] prevData = '0;
   int unsigned csHighCount = 0;
   int unsigned validHighCount = 0;

   // Compare process: stream contents, hold stability and overflow, every cycle
   always @(negedge clk) begin
      cycleCount++;
      if (counterStart) csHighCount++;
      if (msgIf.msg_valid) validHighCount++;
      if (sbEnable && !rst) begin
         if (prevHold) begin
            checkOutput("hold valid", {63'd0, msgIf.msg_valid}, 64'd1);
            checkOutput("hold data", msgIf.msg_out, prevData);
         end
         if (msgIf.msg_valid && msgIf.msg_ready) begin
            if (rxCount < expN)
               checkOutput("stream word", msgIf.msg_out, expBase + 64'(rxCount) + 64'd1);
            else
               checkOutput("stream count", 64'(rxCount + 1), 64'(expN));
            if (rxCount == 0) begin
               firstWord  = msgIf.msg_out;
               firstCycle = cycleCount;
            end
            lastWord  = msgIf.msg_out;
            lastCycle = cycleCount;
            rxCount++;
         end
         if (!allowOverflow) checkOutput("overflow clear", {63'd0, overflow}, 64'd0);
      end
      prevHold = msgIf.msg_valid && !msgIf.msg_ready && start && !rst;
      prevData = msgIf.msg_out;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic [63:0] seed, input logic [31:0] n, input logic rdy);
      step();
      start           = st;
      messageSeed     = seed;
      numMessages     = n;
      msgIf.msg_ready = rdy;
   endtask

   task automatic beginRun(input logic [63:0] seed, input int unsigned n);
      expBase  = seed;
      expN     = n;
      rxCount  = 0;
      sbEnable = 1'b1;
   endtask

   task automatic waitDone(input int unsigned budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (done) break;
      end
      checkOutput("done reached", {63'd0, done}, 64'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; messageSeed = '0; numMessages = '0;
      msgIf.msg_ready = 1'b0;
      forceEn = 1'b0; forceValid = 1'b0; forceValue = '0;
      step(); step();
      checkOutput("reset counter_start", {63'd0, counterStart}, 64'd0);
      checkOutput("reset counter_seed", counterSeed, 64'd0);
      checkOutput("reset msg_valid", {63'd0, msgIf.msg_valid}, 64'd0);
      checkOutput("reset msg_out", msgIf.msg_out, 64'd0);
      checkOutput("reset done", {63'd0, done}, 64'd0);
      checkOutput("reset overflow", {63'd0, overflow}, 64'd0);
      rst = 1'b0;
      step();

      // Test 1: short run, always ready
      $display("[TB] test 1: seed 0x100, n=5");
      beginRun(64'h100, 5);
      applyStimulus(1'b1, 64'h100, 32'd5, 1'b1);
      waitDone(100);
      checkOutput("t1 count", 64'(rxCount), 64'd5);
      checkOutput("t1 first", firstWord, 64'h101);
      checkOutput("t1 last", lastWord, 64'h105);
      checkOutput("t1 back-to-back", 64'(lastCycle - firstCycle), 64'd4);
      applyStimulus(1'b0, 64'h0, 32'd0, 1'b1);
      step();
      checkOutput("t1 done cleared", {63'd0, done}, 64'd0);

      // Test 2: back-pressure pauses the counter, then resumes without gaps
      $display("[TB] test 2: seed 0, n=40, back-pressure");
      beginRun(64'h0, 40);
      applyStimulus(1'b1, 64'h0, 32'd40, 1'b0);
      for (int i = 0; i < 50; i++) begin
         step();
         if (counterStart) break;
      end
      for (int i = 0; i < 200; i++) begin
         step();
         if (!counterStart) break;
      end
      checkOutput("t2 paused", {63'd0, counterStart}, 64'd0);
      for (int i = 0; i < 10; i++) step();
      checkOutput("t2 still paused", {63'd0, counterStart}, 64'd0);
      checkOutput("t2 head", msgIf.msg_out, 64'h1);
      msgIf.msg_ready = 1'b1;
      waitDone(400);
      checkOutput("t2 count", 64'(rxCount), 64'd40);
      checkOutput("t2 first", firstWord, 64'h1);
      checkOutput("t2 last", lastWord, 64'd40);
`ifdef FEEDER_STATS_EN
      checkOutput("t2 pause_count", {63'd0, (pauseCount >= 16'd1)}, 64'd1);
`endif
      applyStimulus(1'b0, 64'h0, 32'd0, 1'b1);
      step();

      // Test 3: zero messages
      $display("[TB] test 3: n=0");
      beginRun(64'h0, 0);
      csHighCount = 0;
      validHighCount = 0;
      applyStimulus(1'b1, 64'h1234, 32'd0, 1'b1);
      step();
      checkOutput("t3 done next cycle", {63'd0, done}, 64'd1);
      for (int i = 0; i < 5; i++) step();
      checkOutput("t3 counter_start never", 64'(csHighCount), 64'd0);
      checkOutput("t3 msg_valid never", 64'(validHighCount), 64'd0);
      applyStimulus(1'b0, 64'h0, 32'd0, 1'b1);
      step();

      // Test 4: 64-bit wrap of the counter value
      $display("[TB] test 4: wrap");
      beginRun(64'hFFFF_FFFF_FFFF_FFFE, 3);
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'd3, 1'b1);
      waitDone(100);
      checkOutput("t4 count", 64'(rxCount), 64'd3);
      checkOutput("t4 first", firstWord, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("t4 last", lastWord, 64'h1);
      applyStimulus(1'b0, 64'h0, 32'd0, 1'b1);
      step();

      // Test 5: abort mid-run with six words queued, then restart
      $display("[TB] test 5: abort and restart");
      beginRun(64'h1000, 100);
      applyStimulus(1'b1, 64'h1000, 32'd100, 1'b0);
      begin
         int unsigned seen = 0;
         for (int i = 0; i < 100 && seen < 6; i++) begin
            step();
            if (counterValid) seen++;
         end
      end
      step();
      start = 1'b0;
      step();
      checkOutput("t5 msg_valid flushed", {63'd0, msgIf.msg_valid}, 64'd0);
      checkOutput("t5 msg_out flushed", msgIf.msg_out, 64'd0);
      step(); step();
      beginRun(64'h50, 3);
      applyStimulus(1'b1, 64'h50, 32'd3, 1'b1);
      waitDone(100);
      checkOutput("t5 first", firstWord, 64'h51);
      checkOutput("t5 count", 64'(rxCount), 64'd3);
      applyStimulus(1'b0, 64'h0, 32'd0, 1'b1);
      step();

      // Test 6: forced words into a full FIFO, then reset
      $display("[TB] test 6: overflow");
      forceEn = 1'b1;
      forceValid = 1'b0;
      beginRun(64'h7000, 1000);
      applyStimulus(1'b1, 64'h7000, 32'd1000, 1'b0);
      step();
      allowOverflow = 1'b1;
      for (int i = 0; i < 17; i++) begin
         forceValid = 1'b1;
         forceValue = 64'h7000 + 64'(i) + 64'd1;
         step();
      end
      forceValid = 1'b0;
      checkOutput("t6 overflow set", {63'd0, overflow}, 64'd1);
      checkOutput("t6 head", msgIf.msg_out, 64'h7001);
      msgIf.msg_ready = 1'b1;
      for (int i = 0; i < 100 && rxCount < 16; i++) step();
      step(); step();
      checkOutput("t6 count", 64'(rxCount), 64'd16);
      checkOutput("t6 last", lastWord, 64'h7010);
      checkOutput("t6 overflow sticky", {63'd0, overflow}, 64'd1);
      rst = 1'b1;
      step();
      checkOutput("t6 rst overflow", {63'd0, overflow}, 64'd0);
      checkOutput("t6 rst counter_start", {63'd0, counterStart}, 64'd0);
      checkOutput("t6 rst counter_seed", counterSeed, 64'd0);
      checkOutput("t6 rst msg_valid", {63'd0, msgIf.msg_valid}, 64'd0);
      checkOutput("t6 rst msg_out", msgIf.msg_out, 64'd0);
      checkOutput("t6 rst done", {63'd0, done}, 64'd0);
`ifdef FEEDER_STATS_EN
      checkOutput("t6 rst pause_count", 64'(pauseCount), 64'd0);
`endif
      start = 1'b0;
      forceEn = 1'b0;
      allowOverflow = 1'b0;
      step();
      rst = 1'b0;
      step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
